// File: rtl/ex_result_arbiter_pkg.sv
// Shared definitions for the EX-stage result arbiter: mux select codes,
// arbiter state encoding and the source-to-select mapping.
package ex_pkg;

  localparam int          SEL_BITS = 4;
  localparam logic [3:0]  SEL_IDLE = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Code 0 aliases source 0 on the mux, so source k is shifted up by one.
  function automatic logic [SEL_BITS-1:0] src_to_sel(input int k);
    return SEL_BITS'(k + 1);
  endfunction

endpackage

// File: rtl/ex_result_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping modulo NUM_SRC, with one optional index masked off.
module rr_pick #(
  parameter int NUM_SRC = 10,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mask_en,
  input  logic [IDX_W-1:0]   mask_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_SRC-1:0] req_m;

  always_comb begin
    req_m = req;
    if (mask_en) req_m[mask_idx] = 1'b0;
  end

  // Walk from the farthest offset down so the nearest hit is written last.
  always_comb begin
    int j;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req_m[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ex_result_arbiter.sv
// Round-robin arbiter for the EX-stage 10:1 result mux: one-hot grant,
// registered mux select, grant held across write-back stalls.
module ex_result_arbiter
  import ex_pkg::*;
#(
  parameter int NUM_SRC = 10,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               wb_ready,
  input  logic               flush,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               wb_valid,
  output logic               busy
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_t         state, state_n;
  logic [NUM_SRC-1:0] gnt_n;
  logic [SEL_W-1:0]   sel_n;
  logic [IDX_W-1:0]   ptr, ptr_n, gidx, gidx_n, g_inc, pick_ptr, pick_idx;
  logic               pick_found, xfer;

  assign xfer     = (state == GRANT) && wb_ready;
  assign g_inc    = (gidx == IDX_W'(NUM_SRC - 1)) ? '0 : gidx + IDX_W'(1);
  assign pick_ptr = xfer ? g_inc : ptr;

  // One search serves both the IDLE pick and the re-pick after a transfer.
  rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_en  (state == GRANT),
    .mask_idx (gidx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    gidx_n  = gidx;
    // A transfer advances the pointer even when a flush cancels the re-pick.
    if (xfer) ptr_n = g_inc;
    if (flush) begin
      state_n = IDLE;
      gnt_n   = '0;
      sel_n   = SEL_IDLE;
    end else if ((state == IDLE) ? |req : wb_ready) begin
      if (pick_found) begin
        state_n = GRANT;
        gnt_n   = NUM_SRC'(1) << pick_idx;
        sel_n   = src_to_sel(int'(pick_idx));
        gidx_n  = pick_idx;
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
        sel_n   = SEL_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= SEL_IDLE;
      ptr      <= '0;
      gidx     <= '0;
      wb_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      gidx     <= gidx_n;
      wb_valid <= |gnt_n;
      busy     <= (state_n == GRANT);
    end
  end

  // A granted source must keep requesting until its transfer cycle.
  a_req_held : assert property (@(posedge clk) disable iff (rst)
    (state == GRANT && !wb_ready && !flush) |-> req[gidx]);

endmodule
